wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of writeback requesters (2..4).
REQ-002 SHALL have parameter DATA_W, default 32, writeback data width.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port src_valid  in  NUM_SRC  per-source writeback request.
REQ-006 SHALL have port src_ready  out  NUM_SRC  per-source grant/accept, one-hot or zero.
REQ-007 SHALL have port src_rd  in  NUM_SRC x 5  per-source destination register.
REQ-008 SHALL have port src_data  in  NUM_SRC x DATA_W  per-source writeback data.
REQ-009 SHALL have port issue_en  in  1  instruction issued this cycle, reserves issue_rd.
REQ-010 SHALL have port issue_rd  in  5  destination of issuing instruction.
REQ-011 SHALL have port rs1, rs2  in  5 each  sources of instruction awaiting issue.
REQ-012 SHALL have port stall  out  1  RAW/WAW hazard, combinational.
REQ-013 SHALL have ports w_en (1), rd (5), w_data (DATA_W)  out  registered register-file write port.

Function
REQ-014 SHALL hold a 32-bit busy scoreboard; bit 0 permanently 0.
REQ-015 SHALL set busy[issue_rd] at clock edge when issue_en=1, stall=0, issue_rd!=0; issue_en SHALL be ignored while stall=1.
REQ-016 SHALL clear busy[rd] at clock edge when registered w_en=1.
REQ-017 SHALL give set priority over clear when both target the same register in the same cycle.
REQ-018 SHALL drive stall=1 when busy[rs1], busy[rs2] or busy[issue_rd] is set (index 0 never stalls); not gated by issue_en.
REQ-019 SHALL grant at most one valid source per cycle; src_ready[i]=1 only if src_valid[i]=1; handshake = valid&ready.
REQ-020 SHALL register the granted source: w_en, rd, w_data valid exactly one cycle after handshake (latency 1).
REQ-021 SHALL drive w_en=0 when no handshake occurred the prior cycle; SHALL force w_en=0 when granted src_rd=0 (handshake still completes, data dropped).
REQ-022 SHALL require sources to hold src_valid, src_rd, src_data stable until accepted; ungranted sources SHALL not be dropped.
REQ-023 SHALL accept a writeback to a non-busy register (no error, write performed).

Reset
REQ-024 SHALL on rst clear busy to 0, w_en=0, rd=0, w_data=0, round-robin pointer to source 0, immediately and asynchronously.
REQ-025 SHALL on rst mid-handshake discard the pending registered write; src_ready SHALL be 0 while rst=1.

Configuration
REQ-026 SHALL support macro WB_ARB_RR_EN: defined -> round-robin, pointer advances to source after last granted index; undefined -> fixed priority, lowest index wins.

Structure
REQ-027 SHALL place NUM_SRC default, register-index width (5) and regfile depth (32) constants in shared package rv32_pkg.
REQ-028 SHALL implement grant selection in sub-module wb_arb_sel (request vector + pointer -> one-hot grant); scoreboard and output register in wb_arbiter.

Verification
REQ-029 SHALL check: issue_en=1, issue_rd=5; next cycle rs1=5 -> stall=1; src0 writes rd=5 data 0xDEADBEEF -> w_en, rd=5, w_data=0xDEADBEEF one cycle later, stall=0 the cycle after.
REQ-030 SHALL check: src0,src1,src2 valid all cycles with rd=1,2,3 -> RR: grants 0,1,2,0; fixed: grant 0 only, others held.
REQ-031 SHALL check: issue_rd=7 with concurrent w_en rd=7 -> busy[7] remains 1, stall on rs2=7 next cycle.
REQ-032 SHALL check: src1 rd=0 data 0x12345678 -> src_ready[1]=1, w_en stays 0, busy unchanged.
REQ-033 SHALL check: busy[3], busy[9] set, handshake pending, assert rst mid-cycle -> w_en=0, stall=0 for rs1=3, rs2=9 without clock edge.

Source files
------------

// File: rtl/rv32_pkg.sv
// Constants shared by the writeback path: register index width, regfile depth
// and the default number of writeback requesters.
package rv32_pkg;

    localparam int NUM_SRC_DEF   = 3;
    localparam int REG_IDX_W     = 5;
    localparam int REGFILE_DEPTH = 32;

endpackage

// File: rtl/wb_arb_sel.sv
// One-hot grant selection: the first asserted request found when scanning
// upward from ptr (wrapping) wins. ptr tied to 0 gives lowest-index-wins.
module wb_arb_sel #(
    parameter int NUM_SRC = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter with register busy scoreboard and a registered regfile
// write port. Define WB_ARB_RR_EN for round-robin grants; otherwise fixed priority.
module wb_arbiter
    import rv32_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DATA_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*REG_IDX_W-1:0]  src_rd,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic                          issue_en,
    input  logic [REG_IDX_W-1:0]          issue_rd,
    input  logic [REG_IDX_W-1:0]          rs1,
    input  logic [REG_IDX_W-1:0]          rs2,
    output logic                          stall,
    output logic                          w_en,
    output logic [REG_IDX_W-1:0]          rd,
    output logic [DATA_W-1:0]             w_data
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [REGFILE_DEPTH-1:0] busy_reg;
    logic [REGFILE_DEPTH-1:0] busy_next;
    logic [NUM_SRC-1:0]       grant;
    logic [PTR_W-1:0]         ptr;
    logic                     hs;
    logic [REG_IDX_W-1:0]     gnt_rd;
    logic [DATA_W-1:0]        gnt_data;
    logic [REG_IDX_W-1:0]     rd_arr   [NUM_SRC];
    logic [DATA_W-1:0]        data_arr [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign rd_arr[gi]   = src_rd[gi*REG_IDX_W +: REG_IDX_W];
            assign data_arr[gi] = src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    wb_arb_sel #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (PTR_W)
    ) u_sel (
        .req   (src_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Nothing may be accepted while reset is held, so a grant never leaks out.
    assign src_ready = rst ? '0 : grant;
    assign hs        = |src_ready;

    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                gnt_rd   = rd_arr[i];
                gnt_data = data_arr[i];
            end
        end
    end

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) gnt_idx = PTR_W'(i);
        end
        ptr_next = ptr_reg;
        if (hs) begin
            ptr_next = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_reg <= '0;
        else     ptr_reg <= ptr_next;
    end

    assign ptr = ptr_reg;
`else
    assign ptr = '0;
`endif

    // Index 0 is never busy, so reads of x0 never stall.
    assign stall = busy_reg[rs1] | busy_reg[rs2] | busy_reg[issue_rd];

    // Set is applied after clear so an issue wins over a same-cycle writeback.
    always_comb begin
        busy_next = busy_reg;
        if (w_en) busy_next[rd] = 1'b0;
        if (issue_en && !stall && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
            w_en     <= 1'b0;
            rd       <= '0;
            w_data   <= '0;
        end else begin
            busy_reg <= busy_next;
            if (hs) begin
                w_en   <= (gnt_rd != '0);
                rd     <= gnt_rd;
                w_data <= gnt_data;
            end else begin
                w_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed hazard/arbitration/reset scenarios followed by
// random traffic checked against a behavioural scoreboard model.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N*5-1:0]  src_rd = '0;
    logic [N*DW-1:0] src_data = '0;
    logic            issue_en = 1'b0;
    logic [4:0]      issue_rd = '0;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic            stall;
    logic            w_en;
    logic [4:0]      rd;
    logic [DW-1:0]   w_data;

    wb_arbiter #(.NUM_SRC(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .w_en      (w_en),
        .rd        (rd),
        .w_data    (w_data)
    );

    always #5 clk = ~clk;

    // Source-side requests as the bench intends them
    bit          sv   [N];
    logic [4:0]  srd  [N];
    logic [31:0] sdat [N];
    logic        t_issue_en;
    logic [4:0]  t_issue_rd, t_rs1, t_rs2;

    // Reference model state
    bit          mbusy [32];
    bit          mw_en;
    logic [4:0]  mrd;
    logic [31:0] mwdata;
    int          mptr;

    int          n_pass  = 0;
    int          n_total = 0;
    int          last_g;
    logic [N-1:0] obs_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            src_valid[i]         = sv[i];
            src_rd[i*5 +: 5]     = srd[i];
            src_data[i*DW +: DW] = sdat[i];
        end
        issue_en = t_issue_en;
        issue_rd = t_issue_rd;
        rs1      = t_rs1;
        rs2      = t_rs2;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_RR_EN
            int idx = (mptr + k) % N;
`else
            int idx = k;
`endif
            if (sv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_stall();
        return mbusy[t_rs1] || mbusy[t_rs2] || mbusy[t_issue_rd];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        mw_en = 1'b0; mrd = '0; mwdata = '0; mptr = 0;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin sv[i] = 1'b0; srd[i] = '0; sdat[i] = '0; end
        t_issue_en = 1'b0; t_issue_rd = '0; t_rs1 = '0; t_rs2 = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        pack();
        #1;
        model_clear();
        check("rst_w_en", w_en, 0);
        check("rst_rd", rd, 0);
        check("rst_w_data", w_data, 0);
        check("rst_ready", src_ready, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic step(input bit rnd);
        int g;
        bit exp_stall;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!sv[i] && ($urandom_range(0, 1) == 1)) begin
                    sv[i]   = 1'b1;
                    srd[i]  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
                    sdat[i] = $urandom;
                end
            end
            t_issue_en = 1'($urandom_range(0, 1));
            t_issue_rd = 5'($urandom_range(0, 7));
            t_rs1      = 5'($urandom_range(0, 7));
            t_rs2      = 5'($urandom_range(0, 7));
        end
        pack();
        #1;
        g         = model_grant();
        exp_stall = model_stall();
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        obs_ready = src_ready;
        check("ready", src_ready, exp_ready);
        check("stall", stall, exp_stall);
        check("w_en", w_en, mw_en);
        if (mw_en) begin
            check("rd", rd, mrd);
            check("w_data", w_data, mwdata);
        end
        if (mw_en) mbusy[mrd] = 1'b0;
        if (t_issue_en && !exp_stall && t_issue_rd != 0) mbusy[t_issue_rd] = 1'b1;
        if (g >= 0) begin
            $display("hs src=%0d rd=%0d data=%h", g, srd[g], sdat[g]);
            mw_en  = (srd[g] != 0);
            mrd    = srd[g];
            mwdata = sdat[g];
            mptr   = (g + 1) % N;
            sv[g]  = 1'b0;
        end else begin
            mw_en = 1'b0;
        end
        last_g = g;
        @(posedge clk);
    endtask

    initial begin
        int exp_seq [4];
        idle_inputs();
        model_clear();
        apply_reset();

        // RAW hazard on x5 resolved by a writeback
        t_issue_en = 1'b1; t_issue_rd = 5'd5;
        step(0);
        t_issue_en = 1'b0; t_issue_rd = 5'd0; t_rs1 = 5'd5;
        step(0);
        #1 check("raw_stall", stall, 1);
        sv[0] = 1'b1; srd[0] = 5'd5; sdat[0] = 32'hDEADBEEF;
        step(0);
        #1;
        check("wb_w_en", w_en, 1);
        check("wb_rd", rd, 5);
        check("wb_data", w_data, 32'hDEADBEEF);
        step(0);
        #1 check("raw_cleared", stall, 0);

        // Three continuously requesting sources
        apply_reset();
`ifdef WB_ARB_RR_EN
        exp_seq = '{0, 1, 2, 0};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N; i++) begin
                sv[i] = 1'b1; srd[i] = 5'(i + 1); sdat[i] = 32'(32'hA0 + i);
            end
            step(0);
            check("arb_grant", obs_ready, N'(1 << exp_seq[c]));
        end

        // Issue to x7 in the same cycle x7 is written back: set wins
        apply_reset();
        sv[0] = 1'b1; srd[0] = 5'd7; sdat[0] = 32'h77;
        step(0);
        t_issue_en = 1'b1; t_issue_rd = 5'd7;
        step(0);
        t_issue_en = 1'b0; t_issue_rd = 5'd0; t_rs2 = 5'd7;
        step(0);
        #1 check("set_wins_stall", stall, 1);

        // Writeback to x0 is accepted but dropped
        apply_reset();
        t_issue_en = 1'b1; t_issue_rd = 5'd4;
        step(0);
        t_issue_en = 1'b0; t_issue_rd = 5'd0;
        sv[1] = 1'b1; srd[1] = 5'd0; sdat[1] = 32'h12345678;
        step(0);
        check("x0_ready", obs_ready, 3'b010);
        #1 check("x0_w_en", w_en, 0);
        t_rs1 = 5'd4;
        step(0);
        #1 check("x0_busy_kept", stall, 1);

        // Asynchronous reset with a write pending in the output register
        apply_reset();
        t_issue_en = 1'b1; t_issue_rd = 5'd3;
        step(0);
        t_issue_rd = 5'd9;
        step(0);
        t_issue_en = 1'b0; t_issue_rd = 5'd0;
        sv[0] = 1'b1; srd[0] = 5'd3; sdat[0] = 32'h33;
        sv[1] = 1'b1; srd[1] = 5'd9; sdat[1] = 32'h99;
        step(0);
        #2;
        rs1 = 5'd3; rs2 = 5'd9;
        #1 check("pre_rst_w_en", w_en, 1);
        rst = 1'b1;
        #1;
        check("arst_w_en", w_en, 0);
        check("arst_stall", stall, 0);
        check("arst_ready", src_ready, 0);
        check("arst_rd", rd, 0);
        idle_inputs();
        model_clear();
        @(negedge clk);
        pack();
        rst = 1'b0;

        // Random traffic against the model
        for (int c = 0; c < 400; c++) step(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
